// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-front-end types and constants.
// The opcode constants are also used by control_unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and imem (slave).
// Handshake: imem_req and imem_addr are held stable until imem_ack. A word
// transfers in any cycle where imem_req & imem_ack, including the first req cycle.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_buffer.sv
// Small FIFO of {pc, instr} pairs feeding decode; flush outranks push and pop.
module fetch_buffer #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2,
  localparam int AW = $clog2(BUF_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_pc,
  input  logic [31:0]     push_instr,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [31:0]     head_instr,
  output logic [CW-1:0]   count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  logic [XLEN-1:0] pc_mem    [BUF_DEPTH];
  logic [31:0]     instr_mem [BUF_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_eff;
  logic            pop_eff;

  assign push_eff   = push && (count < DEPTH_C);
  assign pop_eff    = pop && (count != '0);
  assign head_valid = (count != '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_eff && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_eff) - CW'(pop_eff);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, imem request FSM with redirect squash, and decode-side buffer.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [31:0]         id_instr,
  output logic [XLEN-1:0]     id_pc,
  output logic [6:0]          id_opcode,
  output logic [2:0]          id_funct3,
  output logic                id_funct7_5,
  output logic [1:0]          state_dbg
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_REQ    = REQ;
  localparam logic [1:0] S_SQUASH = SQUASH;

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] sq_addr;
  logic [XLEN-1:0] redir_aligned;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after;
  logic            head_valid;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;
  logic            unused_redir_lsb;

  assign unused_redir_lsb = &{1'b0, redirect_pc[1:0]};
  assign redir_aligned    = {redirect_pc[XLEN-1:2], 2'b00};

  assign imem.imem_req  = (state != S_IDLE);
  assign imem.imem_addr = (state == S_SQUASH) ? sq_addr : pc;

  assign push        = (state == S_REQ) && imem.imem_ack && !redirect_valid;
  assign pop         = head_valid && id_ready;
  assign count_after = count + CW'(push) - CW'(pop && (count != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      sq_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            pc    <= redir_aligned;
            state <= S_REQ;
          end else if (count < DEPTH_C) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            pc <= redir_aligned;
            if (imem.imem_ack) begin
              state <= S_REQ;
            end else begin
              // Keep the old address on the bus until memory finishes it.
              sq_addr <= pc;
              state   <= S_SQUASH;
            end
          end else if (imem.imem_ack) begin
            pc    <= pc + XLEN'(4);
            state <= (count_after < DEPTH_C) ? S_REQ : S_IDLE;
          end
        end
        S_SQUASH: begin
          if (redirect_valid) pc <= redir_aligned;
          if (imem.imem_ack) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fetch_buffer #(
    .XLEN      (XLEN),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (pc),
    .push_instr (imem.imem_rdata),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count)
  );

  assign id_valid    = head_valid;
  assign id_instr    = head_valid ? head_instr : NOP_INSTR;
  assign id_pc       = head_valid ? head_pc : '0;
  assign id_opcode   = id_instr[6:0];
  assign id_funct3   = id_instr[14:12];
  assign id_funct7_5 = id_instr[30];
  assign state_dbg   = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an address-tagged imem model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b1;
  logic        ack_force = 1'b1;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(32)) bus ();

  function automatic logic [31:0] word_of(logic [31:0] a);
    logic [6:0] opc;
    case (a[3:2])
      2'd0:    opc = OP_RTYPE;
      2'd1:    opc = OP_LOAD;
      2'd2:    opc = OP_STORE;
      default: opc = OP_BRANCH;
    endcase
    return {a[31:7] ^ a[24:0], opc};
  endfunction

  assign bus.imem_ack   = bus.imem_req && ack_force;
  assign bus.imem_rdata = word_of(bus.imem_addr);

  instr_fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_opcode      (id_opcode),
    .id_funct3      (id_funct3),
    .id_funct7_5    (id_funct7_5),
    .state_dbg      (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a);
    logic [31:0] w;
    w = word_of(a);
    chk({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
    chk({tag, "_pc"}, id_pc, a);
    chk({tag, "_instr"}, id_instr, w);
    chk({tag, "_opcode"}, {25'd0, id_opcode}, {25'd0, w[6:0]});
    chk({tag, "_funct3"}, {29'd0, id_funct3}, {29'd0, w[14:12]});
    chk({tag, "_f75"}, {31'd0, id_funct7_5}, {31'd0, w[30]});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_nop"}, id_instr, NOP_INSTR);
  endtask

  task automatic reset_release();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state and zero-wait streaming with id_ready high
    tick();
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk_empty("rst");
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE_C()});
    rst = 1'b0;
    tick();
    chk("s1_req", {31'd0, bus.imem_req}, 32'd1);
    chk("s1_addr", bus.imem_addr, 32'h0);
    chk_empty("s1");
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("s1_addr_n", bus.imem_addr, 32'(4 * i));
      chk_head("s1_head", 32'(4 * (i - 1)));
    end

    // Backpressure: two words buffered, fetch stops at pc=8
    id_ready = 1'b0;
    reset_release();
    for (int i = 0; i < 6; i++) tick();
    chk("bp_req", {31'd0, bus.imem_req}, 32'd0);
    chk("bp_state", {30'd0, state_dbg}, {30'd0, S_IDLE_C()});
    chk("bp_pc", bus.imem_addr, 32'h8);
    chk_head("bp_head0", 32'h0);
    id_ready = 1'b1;
    tick();
    chk_head("bp_head4", 32'h4);
    chk("bp_req_still", {31'd0, bus.imem_req}, 32'd0);
    tick();
    chk("bp_resume_req", {31'd0, bus.imem_req}, 32'd1);
    chk("bp_resume_addr", bus.imem_addr, 32'h8);
    chk_empty("bp_drained");
    tick();
    chk_head("bp_head8", 32'h8);

    // Redirect into a slow fetch: old address held, response dropped
    ack_force = 1'b0;
    reset_release();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    ack_force      = 1'b1;
    chk("sq0_state", {30'd0, state_dbg}, {30'd0, S_SQUASH_C()});
    tick();
    ack_force = 1'b0;
    chk("sq_addr10", bus.imem_addr, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("sq_hold1", bus.imem_addr, 32'h10);
    chk("sq_state", {30'd0, state_dbg}, {30'd0, S_SQUASH_C()});
    tick();
    chk("sq_hold2", bus.imem_addr, 32'h10);
    chk_empty("sq_hold2");
    tick();
    chk("sq_hold3", bus.imem_addr, 32'h10);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    chk("sq_new_addr", bus.imem_addr, 32'h100);
    chk("sq_new_req", {31'd0, bus.imem_req}, 32'd1);
    chk_empty("sq_dropped");

    // Redirect coinciding with ack; unaligned target is forced aligned
    ack_force      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    chk("ra_addr", bus.imem_addr, 32'h200);
    chk_empty("ra_flush");

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wr_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_addr1", bus.imem_addr, 32'h0);
    chk_head("wr_head", 32'hFFFF_FFFC);

    // Async reset mid-fetch with one buffered entry
    id_ready  = 1'b0;
    ack_force = 1'b0;
    tick();
    chk("ar_pre_valid", {31'd0, id_valid}, 32'd1);
    chk("ar_pre_req", {31'd0, bus.imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk_empty("ar");
    chk("ar_req", {31'd0, bus.imem_req}, 32'd0);
    chk("ar_pc", id_pc, 32'd0);
    tick();
    id_ready  = 1'b1;
    ack_force = 1'b1;
    rst       = 1'b0;
    tick();
    chk("ar_restart_req", {31'd0, bus.imem_req}, 32'd1);
    chk("ar_restart_addr", bus.imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [1:0] S_IDLE_C();
    return IDLE;
  endfunction

  function automatic logic [1:0] S_SQUASH_C();
    return SQUASH;
  endfunction

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch front end for the 32-bit RISC core. Holds the PC and issues word requests to instruction memory over a req/ack handshake. Buffers returned words in a small FIFO and presents them to the decode stage as opcode/funct3/funct7_5 fields plus the full word, with valid/ready flow control. Branch/jump redirects flush the buffer and squash any in-flight fetch.

Parameters:
XLEN, 32, data and address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request; held until imem_ack
imem_addr  out  XLEN  fetch address (word aligned); stable while imem_req high
imem_ack  in  1  transfer complete this cycle; may be asserted in the same cycle as the first imem_req cycle (zero-wait)
imem_rdata  in  32  instruction word, valid when imem_req & imem_ack
redirect_valid  in  1  branch taken / jump: replace PC, flush
redirect_pc  in  XLEN  new PC; bits [1:0] ignored (forced to 0)
id_valid  out  1  buffer head valid
id_ready  in  1  decode accepts head this cycle
id_instr  out  32  head instruction word; 32'h0000_0013 (NOP) when empty
id_pc  out  XLEN  PC of head instruction
id_opcode  out  7  id_instr[6:0]
id_funct3  out  3  id_instr[14:12]
id_funct7_5  out  1  id_instr[30]

Behaviour:
- Reset (async, any time): state IDLE, pc=RESET_PC, buffer count=0, imem_req=0, id_valid=0, id_instr=NOP, id_pc=0. Any in-flight request is abandoned; imem must tolerate this.
- FSM states: IDLE (req low), REQ (req high, addr=pc), SQUASH (req high, old addr held, response discarded).
- IDLE -> REQ when count<BUF_DEPTH. First posedge after rst deasserts: IDLE->REQ, so imem_req rises one cycle after reset release.
- REQ, ack, no redirect: push {pc, imem_rdata}; pc<=pc+4 (wraps mod 2^32); next REQ if count after push/pop < BUF_DEPTH, else IDLE.
- REQ, no ack, redirect: pc<=redirect_pc, flush, -> SQUASH (addr must stay stable, so old request completes).
- REQ, ack and redirect same cycle: data discarded, pc<=redirect_pc, flush, -> REQ.
- SQUASH: imem_addr = squashed address (held in separate register). On ack: discard data, -> REQ with redirected pc. Further redirect in SQUASH: overwrite pc (latest wins), stay SQUASH until ack.
- IDLE, redirect: pc<=redirect_pc, flush, -> REQ next cycle.
- Buffer: push only from REQ on ack; pop on id_valid & id_ready; simultaneous push+pop leaves count unchanged. Requests are issued only when count<BUF_DEPTH, so overflow is impossible; pop on empty is ignored.
- Flush has priority over push and pop. A head transfer (id_valid & id_ready) coinciding with redirect is treated as consumed; discarding it is decode's responsibility.
- id_* outputs come combinationally from the registered buffer head. Zero-wait ack gives id_valid the cycle after the ack.
- Throughput: one instruction per cycle with zero-wait memory and id_ready held high.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {IDLE, REQ, SQUASH}; NOP_INSTR=32'h0000_0013; opcode constants OP_RTYPE 7'b0110011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011. The opcode constants are shared with control_unit.
- Sub-module fetch_buffer: synchronous FIFO of {pc, instr}, parameter BUF_DEPTH, with push/pop/flush/count and async reset.

Test Plan:
- Reset, then zero-wait imem returning addr-tagged words, id_ready=1 -> imem_addr 0,4,8,...; id_valid from cycle 2; id_pc/id_instr match; id_opcode follows instr[6:0].
- id_ready=0 for 6 cycles -> exactly 2 words buffered; imem_req drops (IDLE); pc=8. Release id_ready -> words at 0 and 4 delivered in order, fetching resumes at 8.
- imem ack latency 3, redirect_pc=0x100 in cycle 1 of a pending fetch of 0x10 -> imem_addr stays 0x10 until ack; data discarded; next request at 0x100; no id_valid for 0x10.
- Redirect and ack in the same cycle (redirect_pc=0x203) -> data dropped, buffer empty next cycle, next imem_addr=0x200.
- pc=0xFFFF_FFFC via redirect, two fetches -> second imem_addr=0x0000_0000 (wrap).
- rst asserted mid-fetch with 1 buffered entry -> outputs reset immediately (id_valid=0, id_instr=NOP, imem_req=0); after release, fetch restarts at RESET_PC.
